pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//   Central hazard controller for the 5-stage RISC-V pipeline. Drives stall/clear of the
//   IF/ID, ID/EX, EX/MEM and MEM/WB registers and EX-stage operand forwarding selects.
//   Sequences load-use bubbles, branch/jump flushes, data-memory wait states (with timeout)
//   and a post-reset pipeline flush. Keeps saturating stall/flush performance counters.
// PARAMETERS
//   INIT_CYCLES  2    cycles of forced flushD/flushE after reset release (>=1)
//   MEM_TIMEOUT  16   max MEM_WAIT cycles before abort + memErr (>=2)
//   CNT_W        32   width of performance counters
// PORTS
//   clk          in   1      clock, all state on posedge
//   rst          in   1      synchronous, active-low reset (0 = reset)
//   Rs1D,Rs2D    in   5      source regs of instruction in ID
//   Rs1E,Rs2E    in   5      source regs of instruction in EX
//   RdE,RdM,RdW  in   5      dest regs in EX / MEM / WB
//   resultSrcE   in   2      2'b01 = instruction in EX is a load
//   regWriteM    in   1      MEM-stage instruction writes RF
//   regWriteW    in   1      WB-stage instruction writes RF
//   PCSrcE       in   1      taken branch / jump resolved in EX
//   memReqM      in   1      MEM stage accesses data memory this cycle
//   memReadyM    in   1      data memory completes access this cycle
//   stallF,stallD,stallE,stallM  out 1  hold PC / IF-ID / ID-EX / EX-MEM
//   flushD,flushE,flushW         out 1  clear IF-ID / ID-EX (clr) / MEM-WB
//   forwardAE,forwardBE          out 2  00 RF, 01 from WB, 10 from MEM
//   memErr       out  1      sticky: MEM_WAIT timed out
//   stallCnt     out  CNT_W  cycles with stallF=1, saturating
//   flushCnt     out  CNT_W  PCSrcE flush events, saturating
// BEHAVIOUR
//   - Reset (rst=0 at posedge): state<=INIT, initCnt<=0, waitCnt<=0, memErr<=0, counters<=0.
//     While in INIT (incl. reset cycle): flushD=flushE=1, all stalls=0, flushW=0.
//   - Forwarding (combinational, all states): forwardAE=10 if regWriteM && RdM!=0 &&
//     RdM==Rs1E; else 01 if regWriteW && RdW!=0 && RdW==Rs1E; else 00. MEM beats WB.
//     forwardBE identical with Rs2E.
//   - FSM states: INIT, RUN, MEM_WAIT.
//   - INIT: initCnt increments; at initCnt==INIT_CYCLES-1 -> RUN. PCSrcE/memReqM ignored.
//   - RUN, priority high->low:
//     1) memReqM && !memReadyM: stallF=stallD=stallE=stallM=1, flushW=1; next MEM_WAIT,
//        waitCnt<=1. No flush, no load-use action this cycle.
//     2) PCSrcE: flushD=flushE=1, stalls 0; flushCnt++ (sat).
//     3) lwStall = resultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D):
//        stallF=stallD=1, flushE=1 (exactly 1 bubble; cleared next cycle when load leaves EX).
//     4) else all stall/flush 0.
//   - MEM_WAIT: stallF..stallM=1, flushW=1 every cycle. PCSrcE/lwStall ignored (held, re-
//     evaluated in RUN). memReadyM=1 -> outputs as in MEM_WAIT this cycle, next RUN,
//     waitCnt<=0. Else if waitCnt==MEM_TIMEOUT-1 -> memErr<=1, next RUN (access aborted).
//     Else waitCnt++.
//   - Latency: memory stall asserted same cycle memReqM&&!memReadyM seen; load-use bubble
//     same cycle as detection; 1-cycle accesses (memReadyM=1) cause no stall.
//   - stallCnt increments on every cycle stallF=1 (load-use or MEM_WAIT entry/hold); both
//     counters hold at 2^CNT_W-1. memErr clears only by reset.
//   - Reset mid-MEM_WAIT or mid-bubble: next cycle in INIT, stalls drop, flushes assert.
// TESTING
//   1) Reset low 3 cycles, release: flushD=flushE=1 for exactly 2 cycles, then RUN, all 0.
//   2) RdM=5,regWriteM=1,RdW=5,regWriteW=1,Rs1E=5 -> forwardAE=10; RdM=0 -> 01; x0 never fwd.
//   3) Load in EX RdE=7, Rs2D=7 -> 1 cycle stallF=stallD=flushE=1, stallCnt=1; then normal.
//   4) memReqM=1, memReadyM=0 for 3 cycles then 1 -> 4 cycles all stalls+flushW, back to RUN,
//      PCSrcE=1 during wait ignored, honored (flushD/E) on first RUN cycle, flushCnt=1.
//   5) memReadyM stuck 0 with MEM_TIMEOUT=16 -> 16 stall cycles, memErr=1 sticky, RUN.
//   6) Force stallCnt near max (CNT_W=4): saturates at 15; rst=0 in MEM_WAIT -> INIT next.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline.
// Generates the stall and flush controls for the pipeline registers and the
// EX-stage forwarding selects. It also sequences the post-reset flush,
// load-use bubbles, taken-branch flushes and data-memory wait states with a
// timeout, and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       resultSrcE,
    input  logic             regWriteM,
    input  logic             regWriteW,
    input  logic             PCSrcE,
    input  logic             memReqM,
    input  logic             memReadyM,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             memErr,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int unsigned WW = $clog2(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_MEM_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    initCnt_q, initCnt_d;
    logic [WW-1:0]    waitCnt_q, waitCnt_d;
    logic             memErr_q, memErr_d;
    logic [CNT_W-1:0] stallCnt_q, flushCnt_q;
    logic             flushEvt;
    logic             lwStall;

    assign lwStall = (resultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

    // Operand forwarding: the younger MEM-stage result wins over WB; x0 never forwards.
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (regWriteM && (RdM != 5'd0) && (RdM == Rs1E))      forwardAE = 2'b10;
        else if (regWriteW && (RdW != 5'd0) && (RdW == Rs1E)) forwardAE = 2'b01;
        if (regWriteM && (RdM != 5'd0) && (RdM == Rs2E))      forwardBE = 2'b10;
        else if (regWriteW && (RdW != 5'd0) && (RdW == Rs2E)) forwardBE = 2'b01;
    end

    // Next-state and stall/flush decode; reset forces the INIT flush pattern immediately.
    always_comb begin
        state_d   = state_q;
        initCnt_d = initCnt_q;
        waitCnt_d = waitCnt_q;
        memErr_d  = memErr_q;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushW    = 1'b0;
        flushEvt  = 1'b0;
        unique case (state_q)
            S_INIT: begin
                flushD    = 1'b1;
                flushE    = 1'b1;
                initCnt_d = initCnt_q + 1'b1;
                if (initCnt_q == IW'(INIT_CYCLES - 1)) state_d = S_RUN;
            end
            S_RUN: begin
                if (memReqM && !memReadyM) begin
                    stallF    = 1'b1;
                    stallD    = 1'b1;
                    stallE    = 1'b1;
                    stallM    = 1'b1;
                    flushW    = 1'b1;
                    waitCnt_d = WW'(1);
                    state_d   = S_MEM_WAIT;
                end else if (PCSrcE) begin
                    flushD   = 1'b1;
                    flushE   = 1'b1;
                    flushEvt = 1'b1;
                end else if (lwStall) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
                if (memReadyM) begin
                    waitCnt_d = '0;
                    state_d   = S_RUN;
                end else if (waitCnt_q == WW'(MEM_TIMEOUT - 1)) begin
                    memErr_d  = 1'b1;
                    waitCnt_d = '0;
                    state_d   = S_RUN;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
        if (!rst) begin
            stallF   = 1'b0;
            stallD   = 1'b0;
            stallE   = 1'b0;
            stallM   = 1'b0;
            flushW   = 1'b0;
            flushD   = 1'b1;
            flushE   = 1'b1;
            flushEvt = 1'b0;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_INIT;
            initCnt_q  <= '0;
            waitCnt_q  <= '0;
            memErr_q   <= 1'b0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            initCnt_q <= initCnt_d;
            waitCnt_q <= waitCnt_d;
            memErr_q  <= memErr_d;
            if (stallF && (stallCnt_q != '1))   stallCnt_q <= stallCnt_q + 1'b1;
            if (flushEvt && (flushCnt_q != '1)) flushCnt_q <= flushCnt_q + 1'b1;
        end
    end

    assign memErr   = memErr_q;
    assign stallCnt = stallCnt_q;
    assign flushCnt = flushCnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a cycle-level reference model
// pushes expected outputs to a scoreboard queue as stimulus is applied, and the
// entries are popped and compared against the DUT before the next clock edge.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned INIT_CYCLES = 2;
    localparam int unsigned MEM_TIMEOUT = 16;
    localparam int unsigned CNT_W       = 4;
    localparam int          CMAX        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]       resultSrcE;
    logic             regWriteM, regWriteW, PCSrcE, memReqM, memReadyM;
    logic             stallF, stallD, stallE, stallM, flushD, flushE, flushW, memErr;
    logic [1:0]       forwardAE, forwardBE;
    logic [CNT_W-1:0] stallCnt, flushCnt;

    pipeline_hazard_ctrl #(
        .INIT_CYCLES(INIT_CYCLES),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .resultSrcE(resultSrcE),
        .regWriteM(regWriteM), .regWriteW(regWriteW), .PCSrcE(PCSrcE),
        .memReqM(memReqM), .memReadyM(memReadyM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .memErr(memErr), .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] ctl;   // stallF stallD stallE stallM flushD flushE flushW
        logic [1:0] fa;
        logic [1:0] fb;
        logic       err;
        logic [7:0] sc;
        logic [7:0] fc;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: 0 = INIT, 1 = RUN, 2 = MEM_WAIT
    int m_st = 0, m_init = 0, m_wait = 0, m_err = 0, m_sc = 0, m_fc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (regWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (regWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_lw();
        return resultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    function automatic exp_t ref_out();
        exp_t e;
        e     = '0;
        e.fa  = ref_fwd(Rs1E);
        e.fb  = ref_fwd(Rs2E);
        e.err = (m_err != 0);
        e.sc  = 8'(m_sc);
        e.fc  = 8'(m_fc);
        if (!rst || m_st == 0)                e.ctl = 7'b0000110;
        else if (m_st == 2)                   e.ctl = 7'b1111001;
        else if (memReqM && !memReadyM)       e.ctl = 7'b1111001;
        else if (PCSrcE)                      e.ctl = 7'b0000110;
        else if (ref_lw())                    e.ctl = 7'b1100010;
        else                                  e.ctl = 7'b0000000;
        return e;
    endfunction

    task automatic ref_clock(input exp_t e);
        if (!rst) begin
            m_st = 0; m_init = 0; m_wait = 0; m_err = 0; m_sc = 0; m_fc = 0;
            return;
        end
        if (e.ctl[6] && m_sc < CMAX) m_sc++;
        case (m_st)
            0: begin
                if (m_init == INIT_CYCLES - 1) m_st = 1;
                m_init++;
            end
            1: begin
                if (memReqM && !memReadyM) begin
                    m_st = 2; m_wait = 1;
                end else if (PCSrcE && m_fc < CMAX) m_fc++;
            end
            default: begin
                if (memReadyM) begin
                    m_st = 1; m_wait = 0;
                end else if (m_wait == MEM_TIMEOUT - 1) begin
                    m_err = 1; m_st = 1; m_wait = 0;
                end else m_wait++;
            end
        endcase
    endtask

    // One cycle: push the model prediction, compare before the edge, then advance.
    task automatic step();
        exp_t e, g;
        e = ref_out();
        sbq.push_back(e);
        #3;
        g = sbq.pop_front();
        check_eq("ctl", {stallF, stallD, stallE, stallM, flushD, flushE, flushW}, 32'(g.ctl));
        check_eq("forwardAE", 32'(forwardAE), 32'(g.fa));
        check_eq("forwardBE", 32'(forwardBE), 32'(g.fb));
        check_eq("memErr", 32'(memErr), 32'(g.err));
        check_eq("stallCnt", 32'(stallCnt), 32'(g.sc));
        check_eq("flushCnt", 32'(flushCnt), 32'(g.fc));
        @(posedge clk);
        ref_clock(g);
        #1;
    endtask

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        resultSrcE = 0; regWriteM = 0; regWriteW = 0; PCSrcE = 0;
        memReqM = 0; memReadyM = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset held, then released: two INIT flush cycles, then quiet RUN.
        for (int i = 0; i < 2; i++) begin
            #2; check_eq("rst_flushD", 32'(flushD), 32'd1);
            step();
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2; check_eq("init_flushE", 32'(flushE), 32'd1);
            step();
        end
        #2; check_eq("run_flushD", 32'(flushD), 32'd0);
        step();

        // Forwarding priority and x0 suppression.
        Rs1E = 5; Rs2E = 5; RdM = 5; RdW = 5; regWriteM = 1; regWriteW = 1;
        #2; check_eq("fwd_mem", 32'(forwardAE), 32'd2);
        step();
        RdM = 0;
        #2; check_eq("fwd_wb", 32'(forwardAE), 32'd1);
        step();
        Rs1E = 0; Rs2E = 0; RdW = 0;
        #2; check_eq("fwd_x0", 32'(forwardBE), 32'd0);
        step();
        idle_inputs();

        // Load-use bubble: exactly one cycle.
        resultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        #2; check_eq("lw_stallF", 32'(stallF), 32'd1);
        step();
        check_eq("lw_stallCnt", 32'(stallCnt), 32'd1);
        resultSrcE = 2'b00;
        step();
        resultSrcE = 2'b01; RdE = 0; Rs2D = 0;
        step();
        idle_inputs();

        // Memory wait 3+1 cycles, PCSrcE held across the wait.
        memReqM = 1; PCSrcE = 1;
        for (int i = 0; i < 3; i++) step();
        memReadyM = 1;
        step();
        memReqM = 0; memReadyM = 0;
        #2; check_eq("br_after_wait", 32'(flushD), 32'd1);
        step();
        PCSrcE = 0;
        check_eq("flushCnt_one", 32'(flushCnt), 32'd1);
        step();

        // Timeout: memReadyM stuck low.
        memReqM = 1;
        for (int i = 0; i < MEM_TIMEOUT; i++) step();
        memReqM = 0;
        check_eq("memErr_set", 32'(memErr), 32'd1);
        check_eq("stallCnt_sat", 32'(stallCnt), 32'(CMAX));
        for (int i = 0; i < 3; i++) step();
        check_eq("memErr_sticky", 32'(memErr), 32'd1);

        // Reset while waiting on memory.
        memReqM = 1;
        step(); step();
        rst = 0;
        #2; check_eq("rst_wait_stall", 32'(stallF), 32'd0);
        step();
        rst = 1; memReqM = 0;
        #2; check_eq("rst_wait_init", 32'(flushE), 32'd1);
        step(); step(); step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            Rs1D       = 5'($urandom_range(0, 7));
            Rs2D       = 5'($urandom_range(0, 7));
            Rs1E       = 5'($urandom_range(0, 7));
            Rs2E       = 5'($urandom_range(0, 7));
            RdE        = 5'($urandom_range(0, 7));
            RdM        = 5'($urandom_range(0, 7));
            RdW        = 5'($urandom_range(0, 7));
            resultSrcE = 2'($urandom_range(0, 3));
            regWriteM  = 1'($urandom_range(0, 1));
            regWriteW  = 1'($urandom_range(0, 1));
            PCSrcE     = ($urandom_range(0, 4) == 0);
            memReqM    = ($urandom_range(0, 9) < 4);
            memReadyM  = ($urandom_range(0, 9) < 3);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
